// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Source-side and pin-side signals of the VGA timing generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic [1:0]    mode;
    logic [15:0]   pix_data;
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [15:0]   rgb;
    logic          frame_start;

    modport master (
        input  mode, pix_data,
        output pix_req, pix_x, pix_y, hsync, vsync, de, rgb, frame_start
    );

    modport slave (
        output mode, pix_data,
        input  pix_req, pix_x, pix_y, hsync, vsync, de, rgb, frame_start
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA timing with 2-stage pixel output path and modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);
    localparam int            c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int            c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] c_h_last   = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last   = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_act    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_v_act    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_hs_start = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_end   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_vs_start = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_end   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          c_hs_on    = (HS_POL != 0);
    localparam logic          c_vs_on    = (VS_POL != 0);
    // Guard against a zero bar width for very narrow configurations.
    localparam int            c_bar_w_i  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [CW-1:0] c_bar_w    = CW'(c_bar_w_i);

    logic [CW-1:0] r_h_cnt, r_v_cnt;
    logic          w_pix_req, w_hs_act, w_vs_act;
    logic [1:0]    r_mode_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_pix_req = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act) && rst_n;
    assign w_hs_act  = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_vs_act  = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);

    assign vga.pix_req = w_pix_req;
    assign vga.pix_x   = w_pix_req ? r_h_cnt : '0;
    assign vga.pix_y   = w_pix_req ? r_v_cnt : '0;

    // Mode only changes on a frame boundary so a frame is never mixed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_q <= 2'd0;
        end else if (r_h_cnt == '0 && r_v_cnt == '0) begin
            r_mode_q <= vga.mode;
        end
    end

    logic          r_de1, r_hs1, r_vs1;
    logic [CW-1:0] r_x1, r_y1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_de1 <= 1'b0;
            r_hs1 <= ~c_hs_on;
            r_vs1 <= ~c_vs_on;
            r_x1  <= '0;
            r_y1  <= '0;
        end else begin
            r_de1 <= w_pix_req;
            r_hs1 <= w_hs_act ? c_hs_on : ~c_hs_on;
            r_vs1 <= w_vs_act ? c_vs_on : ~c_vs_on;
            r_x1  <= vga.pix_x;
            r_y1  <= vga.pix_y;
        end
    end

    // Grayscale: expand RGB565 to 8-bit channels, weighted sum, keep Y[7:2].
    logic [7:0]  w_r8, w_g8, w_b8;
    logic [15:0] w_y;
    logic [5:0]  w_luma6;
    logic [15:0] w_gray;

    assign w_r8    = {vga.pix_data[15:11], vga.pix_data[15:13]};
    assign w_g8    = {vga.pix_data[10:5],  vga.pix_data[10:9]};
    assign w_b8    = {vga.pix_data[4:0],   vga.pix_data[4:2]};
    assign w_y     = 16'd77 * {8'd0, w_r8} + 16'd150 * {8'd0, w_g8} + 16'd29 * {8'd0, w_b8};
    assign w_luma6 = 6'(w_y >> 10);
    assign w_gray  = {w_luma6[5:1], w_luma6, w_luma6[5:1]};

    logic [CW-1:0] w_bar_raw;
    logic [2:0]    w_bar_idx;
    logic [15:0]   w_bar;

    assign w_bar_raw = r_x1 / c_bar_w;
    assign w_bar_idx = (w_bar_raw > CW'(7)) ? 3'd7 : w_bar_raw[2:0];

    always_comb begin
        w_bar = 16'h0000;
        case (w_bar_idx)
            3'd0:    w_bar = 16'hFFFF;
            3'd1:    w_bar = 16'hFFE0;
            3'd2:    w_bar = 16'h07FF;
            3'd3:    w_bar = 16'h07E0;
            3'd4:    w_bar = 16'hF81F;
            3'd5:    w_bar = 16'hF800;
            3'd6:    w_bar = 16'h001F;
            default: w_bar = 16'h0000;
        endcase
    end

    logic [15:0] w_rgb;

    always_comb begin
        w_rgb = 16'h0000;
        if (r_de1) begin
            case (r_mode_q)
                2'd0:    w_rgb = vga.pix_data;
                2'd1:    w_rgb = w_gray;
                2'd2:    w_rgb = w_bar;
                default: w_rgb = 16'h0000;
            endcase
        end
    end

    logic        r_de2, r_hs2, r_vs2, r_fs2;
    logic [15:0] r_rgb2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_de2  <= 1'b0;
            r_hs2  <= ~c_hs_on;
            r_vs2  <= ~c_vs_on;
            r_rgb2 <= 16'h0000;
            r_fs2  <= 1'b0;
        end else begin
            r_de2  <= r_de1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_rgb2 <= w_rgb;
            r_fs2  <= r_de1 && (r_x1 == '0) && (r_y1 == '0);
        end
    end

    assign vga.de          = r_de2;
    assign vga.hsync       = r_hs2;
    assign vga.vsync       = r_vs2;
    assign vga.rgb         = r_rgb2;
    assign vga.frame_start = r_fs2;

endmodule

`default_nettype wire
